// File: rtl/gyro_spi_pkg.sv
// gyro_spi_pkg: definitions shared by the gyro SPI responder and its helpers.
//   DEFAULT_ADDR_W / DEFAULT_DATA_W : default register address / data widths
//   SPI_RW_READ                     : value of the R/W command bit for a read
//   spi_resp_state_t                : responder FSM state encoding
package gyro_spi_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 7;
    localparam int unsigned DEFAULT_DATA_W = 16;

    localparam logic SPI_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_FETCH,
        RD_DATA,
        WR_DATA,
        DONE
    } spi_resp_state_t;

endpackage

// File: rtl/gyro_spi_sync_edge.sv
// gyro_spi_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall detector
// for one asynchronous input. SYNC_STAGES must be 2 or 3.
//   clk, rst  : local clock, synchronous active-high reset
//   async_in  : asynchronous input
//   sync_out  : synchronised level
//   rise/fall : one-clk pulses on synchronised 0->1 / 1->0 transitions
module gyro_spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/gyro_spi_responder.sv
// gyro_spi_responder: device-side 3-wire SPI (mode 0) responder that decodes
// read/write frames {R/W, addr[ADDR_W], data[DATA_W]} MSB first and accesses
// a register space through a single-cycle register port.
// Optional feature: define SPI_RESP_AUTOINC_EN for burst mode (address
// auto-increment, wrapping, one strobe per data word while CS stays low).
//   clk, rst          : clock, synchronous active-high reset
//   spi_sck, spi_cs   : SPI clock / active-low chip select (asynchronous)
//   spi_d_i           : SPI_D pad input
//   spi_d_o, spi_d_oe : SPI_D pad output value / output enable
//   reg_addr          : register address, valid with reg_we / reg_re
//   reg_wdata, reg_we : write data and one-cycle write strobe
//   reg_re, reg_rdata : one-cycle read strobe; read data sampled 1 clk later
//   frame_err         : one-cycle pulse when CS deasserts mid-frame
module gyro_spi_responder
    import gyro_spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_d_i,
    output logic              spi_d_o,
    output logic              spi_d_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err
);

`ifdef SPI_RESP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int unsigned CNT_MAX = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise_unused, cs_fall_unused;
    logic d_s, d_rise_unused, d_fall_unused;

    gyro_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .async_in(spi_sck),
        .sync_out(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    gyro_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .async_in(spi_cs),
        .sync_out(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
    );
    gyro_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d (
        .clk(clk), .rst(rst), .async_in(spi_d_i),
        .sync_out(d_s), .rise(d_rise_unused), .fall(d_fall_unused)
    );

    spi_resp_state_t   state, next_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] cmd_sr;
    logic [DATA_W-1:0] rx_sr, tx_sr;
    logic              cs_armed;   // CS seen high since reset
    logic              burst_q;    // at least one word of this frame complete
    logic              frame_abort;
    logic              cmd_last, data_last, rd_done, word_gap;

    assign cmd_last  = sck_rise && (bit_cnt == CNT_W'(ADDR_W));
    assign data_last = sck_rise && (bit_cnt == CNT_W'(DATA_W - 1));
    // Read word ends on the fall after the last rise, so the master keeps
    // the final bit for its whole high phase.
    assign rd_done   = sck_fall && (bit_cnt == CNT_W'(DATA_W));
    // CS rising between burst words is a clean end of frame, not an abort.
    assign word_gap  = burst_q && (bit_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        frame_abort = 1'b0;
        case (state)
            IDLE: if (!cs_s && cs_armed) next_state = CMD;
            CMD: begin
                if (cs_s) begin
                    next_state  = IDLE;
                    frame_abort = 1'b1;
                end else if (cmd_last) begin
                    next_state = (cmd_sr[ADDR_W-1] == SPI_RW_READ) ? RD_FETCH : WR_DATA;
                end
            end
            RD_FETCH: begin
                if (cs_s) begin
                    next_state  = IDLE;
                    frame_abort = !word_gap;
                end else begin
                    next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                if (cs_s) begin
                    next_state  = IDLE;
                    frame_abort = !word_gap;
                end else if (rd_done) begin
                    next_state = AUTOINC ? RD_FETCH : DONE;
                end
            end
            WR_DATA: begin
                // Final rise wins over a simultaneous CS deassertion.
                if (data_last) begin
                    next_state = (AUTOINC && !cs_s) ? WR_DATA : DONE;
                end else if (cs_s) begin
                    next_state  = IDLE;
                    frame_abort = !word_gap;
                end
            end
            DONE: if (cs_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
            cs_armed  <= 1'b0;
            burst_q   <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= frame_abort;
            if (cs_s) cs_armed <= 1'b1;
            // Step the write address once the strobe for the current word is out.
            if (AUTOINC && reg_we) reg_addr <= reg_addr + 1'b1;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    burst_q <= 1'b0;
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_sr  <= {cmd_sr[ADDR_W-2:0], d_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (cmd_last) begin
                            bit_cnt  <= '0;
                            reg_addr <= {cmd_sr[ADDR_W-2:0], d_s};
                            reg_re   <= (next_state == RD_FETCH);
                        end
                    end
                end
                RD_FETCH: tx_sr <= reg_rdata;
                RD_DATA: begin
                    if (sck_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (rd_done) begin
                        bit_cnt <= '0;
                        if (next_state == RD_FETCH) begin
                            reg_addr <= reg_addr + 1'b1;
                            reg_re   <= 1'b1;
                            burst_q  <= 1'b1;
                        end
                    end else if (sck_fall && bit_cnt != '0) begin
                        // The fall before the first data rise must not shift:
                        // the MSB is presented from entry.
                        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
                WR_DATA: begin
                    if (sck_rise) begin
                        rx_sr   <= {rx_sr[DATA_W-2:0], d_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (data_last) begin
                            bit_cnt   <= '0;
                            reg_wdata <= {rx_sr[DATA_W-2:0], d_s};
                            reg_we    <= 1'b1;
                            burst_q   <= AUTOINC;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_d_oe = (state == RD_DATA);
    assign spi_d_o  = spi_d_oe & tx_sr[DATA_W-1];

endmodule

// File: tb/tb_gyro_spi_responder.sv
// tb_gyro_spi_responder: directed frames from a bit-level SPI master model;
// expected register-port strobes are queued per frame and popped by an
// independent monitor whenever the responder raises a strobe.
module tb_gyro_spi_responder;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam logic [1:0] EV_WE  = 2'd0;
    localparam logic [1:0] EV_RE  = 2'd1;
    localparam logic [1:0] EV_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ev_t;

    logic              clk, rst;
    logic              spi_sck, spi_cs, spi_d_i, spi_d_o, spi_d_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata, reg_rdata;
    logic              reg_we, reg_re, frame_err;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    bit  oe_allowed;
    bit  oe_bad;

    gyro_spi_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_d_i(spi_d_i),
        .spi_d_o(spi_d_o), .spi_d_oe(spi_d_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register map seen by reads (combinational single-cycle slave).
    always_comb begin
        case (reg_addr)
            7'h2A:   reg_rdata = 16'h1234;
            7'h02:   reg_rdata = 16'hC3C3;
            7'h55:   reg_rdata = 16'h8001;
            default: reg_rdata = 16'h0000;
        endcase
    end

    function automatic logic [31:0] outs();
        return {4'b0, spi_d_o, spi_d_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_err};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input ev_t act);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got kind=%0d addr=%h data=%h, required no strobe",
                     act.kind, act.addr, act.data);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL strobe: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         act.kind, act.addr, act.data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, pops one expectation per strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_d_oe && !oe_allowed) oe_bad = 1'b1;
            if (reg_we)    got_ev({EV_WE, reg_addr, reg_wdata});
            if (reg_re)    got_ev({EV_RE, reg_addr, 16'h0000});
            if (frame_err) got_ev({EV_ERR, 7'h00, 16'h0000});
        end
    end

    // SPI master, mode 0. For reads w0 is the word the master must receive.
    // nbits < 16 raises CS early; rst_bit >= 0 pulses rst during that data bit.
    task automatic spi_xfer(input bit rd, input logic [6:0] addr,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input int nwords, input int nbits, input int hp, input int rst_bit);
        logic [7:0]  cmd;
        logic [15:0] wd, rx;
        bit          oe_ok;
        cmd    = {rd, addr};
        rx     = '0;
        oe_ok  = 1'b1;
        oe_bad = 1'b0;
        spi_cs = 1'b0;
        repeat (hp) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            spi_d_i = cmd[i];
            repeat (hp) @(negedge clk);
            spi_sck = 1'b1;
            if (i == 0 && rd) oe_allowed = 1'b1;
            repeat (hp) @(negedge clk);
            spi_sck = 1'b0;
        end
        for (int w = 0; w < nwords; w++) begin
            wd = (w == 0) ? w0 : w1;
            for (int k = 0; k < nbits; k++) begin
                if (!rd) spi_d_i = wd[15-k];
                repeat (hp) @(negedge clk);
                spi_sck = 1'b1;
                if (rd) begin
                    rx[15-k] = spi_d_o;
                    if (!spi_d_oe) oe_ok = 1'b0;
                end
                if (rst_bit == k) begin
                    @(negedge clk);
                    rst        = 1'b1;
                    oe_allowed = 1'b0;
                    @(negedge clk);
                    check("reset_mid_frame_outputs", outs(), 32'h0);
                    rst = 1'b0;
                end
                repeat (hp) @(negedge clk);
                spi_sck = 1'b0;
            end
        end
        spi_d_i = 1'b0;
        repeat (hp) @(negedge clk);
        spi_cs     = 1'b1;
        oe_allowed = 1'b0;
        repeat (2 * hp) @(negedge clk);
        if (rd && nbits == 16 && rst_bit < 0) begin
            check("read_word", {16'h0, rx}, {16'h0, w0});
            check("oe_high_during_data", {31'h0, oe_ok}, 32'h1);
        end
        check("oe_outside_data", {31'h0, oe_bad}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        spi_cs     = 1'b1;
        spi_sck    = 1'b0;
        spi_d_i    = 1'b0;
        oe_allowed = 1'b0;
        oe_bad     = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", outs(), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single write and read, SCK period 10 clk.
        push_exp(EV_WE, 7'h15, 16'hBEEF);
        spi_xfer(1'b0, 7'h15, 16'hBEEF, 16'h0, 1, 16, 5, -1);
        push_exp(EV_RE, 7'h2A, 16'h0);
        spi_xfer(1'b1, 7'h2A, 16'h1234, 16'h0, 1, 16, 5, -1);

        // Abort after 12 write-data bits, then a clean frame.
        push_exp(EV_ERR, 7'h00, 16'h0);
        spi_xfer(1'b0, 7'h33, 16'hDEAD, 16'h0, 1, 12, 5, -1);
        push_exp(EV_WE, 7'h0C, 16'h5A5A);
        spi_xfer(1'b0, 7'h0C, 16'h5A5A, 16'h0, 1, 16, 5, -1);

        // Reset during data bit 5 of a read; the rest of that frame is ignored.
        push_exp(EV_RE, 7'h2A, 16'h0);
        spi_xfer(1'b1, 7'h2A, 16'h1234, 16'h0, 1, 16, 5, 5);
        push_exp(EV_RE, 7'h2A, 16'h0);
        spi_xfer(1'b1, 7'h2A, 16'h1234, 16'h0, 1, 16, 5, -1);

        // Minimum SCK period (8 clk), back-to-back frames.
        push_exp(EV_WE, 7'h01, 16'hA5A5);
        spi_xfer(1'b0, 7'h01, 16'hA5A5, 16'h0, 1, 16, 4, -1);
        push_exp(EV_RE, 7'h02, 16'h0);
        spi_xfer(1'b1, 7'h02, 16'hC3C3, 16'h0, 1, 16, 4, -1);
        push_exp(EV_WE, 7'h7E, 16'h1357);
        spi_xfer(1'b0, 7'h7E, 16'h1357, 16'h0, 1, 16, 4, -1);
        push_exp(EV_RE, 7'h55, 16'h0);
        spi_xfer(1'b1, 7'h55, 16'h8001, 16'h0, 1, 16, 4, -1);

        // Two-word write to the top address.
`ifdef SPI_RESP_AUTOINC_EN
        push_exp(EV_WE, 7'h7F, 16'h0001);
        push_exp(EV_WE, 7'h00, 16'h0002);
`else
        push_exp(EV_WE, 7'h7F, 16'h0001);
`endif
        spi_xfer(1'b0, 7'h7F, 16'h0001, 16'h0002, 2, 16, 5, -1);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
